// File: rtl/pit_irq_ctrl.sv
// Interrupt aggregator for PIT-style request lines: pending/mask/mode registers,
// lowest-index-wins vectored interrupt, Wishbone slave for software access.
module pit_irq_ctrl #(
  parameter int NUM_SRC      = 4,
  parameter int DWIDTH       = 16,
  parameter bit SINGLE_CYCLE = 1'b0
) (
  input  logic               wb_clk_i,
  input  logic               arst_i,
  input  logic [2:0]         wb_adr_i,
  input  logic [DWIDTH-1:0]  wb_dat_i,
  output logic [DWIDTH-1:0]  wb_dat_o,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  input  logic [1:0]         wb_sel_i,
  output logic               wb_ack_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               irq_o,
  output logic [3:0]         irq_vec_o,
  output logic               irq_valid_o
);

  localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

  localparam logic [2:0] ADR_PEND  = 3'd0;
  localparam logic [2:0] ADR_MASK  = 3'd1;
  localparam logic [2:0] ADR_MODE  = 3'd2;
  localparam logic [2:0] ADR_VEC   = 3'd3;
  localparam logic [2:0] ADR_RAW   = 3'd4;
  localparam logic [2:0] ADR_SWSET = 3'd5;

  logic [15:0] src_q, pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
  logic        ack_q, irq_q, valid_q;
  logic [3:0]  vec_q, vec_d;
  logic        req, wr_en;
  logic [15:0] lane, wr_bits, rise, act, w1c, swset, edge_next;

  assign req      = wb_stb_i & wb_cyc_i;
  assign wb_ack_o = SINGLE_CYCLE ? req : ack_q;
  assign wr_en    = req & wb_we_i & wb_ack_o;

  // Registers are kept 16 bits wide; bits at or above NUM_SRC are forced to zero.
  assign lane    = {{8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wr_bits = wb_dat_i & lane & SRC_MASK;
  assign rise    = 16'(irq_src_i) & ~src_q;
  assign act     = pend_q & mask_q;

  assign w1c       = (wr_en && wb_adr_i == ADR_PEND)  ? wr_bits : 16'h0000;
  assign swset     = (wr_en && wb_adr_i == ADR_SWSET) ? wr_bits : 16'h0000;
  assign edge_next = (pend_q & ~w1c) | rise | swset;
  assign pend_d    = (mode_q & edge_next) | (~mode_q & src_q);

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && wb_adr_i == ADR_MASK) mask_d = (mask_q & ~lane) | wr_bits;
    if (wr_en && wb_adr_i == ADR_MODE) mode_d = (mode_q & ~lane) | wr_bits;
  end

  // Scanning downward lets the lowest set index overwrite, so source 0 has top priority.
  always_comb begin
    vec_d = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (act[i]) vec_d = 4'(i);
    end
  end

  always_comb begin
    case (wb_adr_i)
      ADR_PEND: wb_dat_o = pend_q;
      ADR_MASK: wb_dat_o = mask_q;
      ADR_MODE: wb_dat_o = mode_q;
      ADR_VEC:  wb_dat_o = {valid_q, 11'b0, vec_q};
      ADR_RAW:  wb_dat_o = src_q;
      default:  wb_dat_o = 16'h0000;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      src_q   <= 16'h0000;
      pend_q  <= 16'h0000;
      mask_q  <= 16'h0000;
      mode_q  <= 16'h0000;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      valid_q <= 1'b0;
      vec_q   <= 4'd0;
    end else begin
      src_q   <= 16'(irq_src_i);
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      ack_q   <= req & ~ack_q;
      irq_q   <= |act;
      valid_q <= |act;
      vec_q   <= vec_d;
    end
  end

  assign irq_o       = irq_q;
  assign irq_valid_o = valid_q;
  assign irq_vec_o   = vec_q;

endmodule
